vga_plot_arbiter: RTL and testbench

//  Shares the single VGA adapter pixel-write port (VGA_x/VGA_y/VGA_color/VGA_write) between

---
 rtl/vga_plot_arbiter.sv | 147 ++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing one VGA adapter pixel-write port among NREQ producers,
// with a built-in engine that fills the whole frame with BG_COLOR one pixel per cycle.
module vga_plot_arbiter #(
  parameter int NREQ        = 3,
  parameter int X_MAX       = 160,
  parameter int Y_MAX       = 120,
  parameter int COLOR_DEPTH = 9,
  parameter logic [COLOR_DEPTH-1:0] BG_COLOR = '0
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*8-1:0]           req_x,
  input  logic [NREQ*7-1:0]           req_y,
  input  logic [NREQ*COLOR_DEPTH-1:0] req_color,
  output logic [NREQ-1:0]             gnt,
  input  logic                        clear_start,
  output logic                        clear_busy,
  output logic                        clear_done,
  output logic [7:0]                  VGA_x,
  output logic [6:0]                  VGA_y,
  output logic [COLOR_DEPTH-1:0]      VGA_color,
  output logic                        VGA_write,
  output logic                        dbg_state_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] P_LAST   = PW'(NREQ - 1);
  localparam logic [7:0]    X_LAST   = 8'(X_MAX - 1);
  localparam logic [6:0]    Y_LAST   = 7'(Y_MAX - 1);
  localparam bit            ONE_PIX  = (X_MAX == 1) && (Y_MAX == 1);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t                   state_q;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [7:0]               cx_q, cx_d;
  logic [6:0]               cy_q, cy_d;
  logic [PW-1:0]            gnt_idx;
  logic                     found;
  logic [7:0]               sel_x;
  logic [6:0]               sel_y;
  logic [COLOR_DEPTH-1:0]   sel_c;

  assign dbg_state_o = (state_q == S_CLEAR);

  // Search starts at the pointer and wraps; clear_start steals the cycle from requesters.
  always_comb begin
    logic [PW:0] s;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    s       = '0;
    if (!reset && state_q == S_IDLE && !clear_start) begin
      for (int k = 0; k < NREQ; k++) begin
        s = {1'b0, ptr_q} + (PW+1)'(k);
        if (s >= (PW+1)'(NREQ)) s = s - (PW+1)'(NREQ);
        if (!found && req[s[PW-1:0]]) begin
          found        = 1'b1;
          gnt_idx      = s[PW-1:0];
          gnt[s[PW-1:0]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_x = req_x[8*i +: 8];
        sel_y = req_y[7*i +: 7];
        sel_c = req_color[COLOR_DEPTH*i +: COLOR_DEPTH];
      end
    end
    ptr_d = (gnt_idx == P_LAST) ? '0 : gnt_idx + PW'(1);
    if (cx_q == X_LAST) begin
      cx_d = '0;
      cy_d = cy_q + 7'd1;
    end else begin
      cx_d = cx_q + 8'd1;
      cy_d = cy_q;
    end
  end

  // Counters hold the pixel currently on the VGA outputs during a sweep.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      VGA_x      <= '0;
      VGA_y      <= '0;
      VGA_color  <= '0;
      VGA_write  <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clear_start) begin
            state_q    <= S_CLEAR;
            cx_q       <= '0;
            cy_q       <= '0;
            VGA_x      <= '0;
            VGA_y      <= '0;
            VGA_color  <= BG_COLOR;
            VGA_write  <= 1'b1;
            clear_busy <= 1'b1;
            clear_done <= ONE_PIX;
          end else if (found) begin
            VGA_x      <= sel_x;
            VGA_y      <= sel_y;
            VGA_color  <= sel_c;
            VGA_write  <= 1'b1;
            ptr_q      <= ptr_d;
            clear_done <= 1'b0;
          end else begin
            VGA_write  <= 1'b0;
            clear_done <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (cx_q == X_LAST && cy_q == Y_LAST) begin
            state_q    <= S_IDLE;
            VGA_write  <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
          end else begin
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            VGA_x      <= cx_d;
            VGA_y      <= cy_d;
            VGA_color  <= BG_COLOR;
            VGA_write  <= 1'b1;
            clear_done <= (cx_d == X_LAST) && (cy_d == Y_LAST);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomized bench for vga_plot_arbiter against a pixel-index reference model.
module tb_vga_plot_arbiter;
  localparam int NREQ = 3;
  localparam int XM   = 160;
  localparam int YM   = 120;
  localparam int CD   = 9;
  localparam int NPIX = XM * YM;
  localparam logic [CD-1:0] BG = 9'h000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*8-1:0]    req_x;
  logic [NREQ*7-1:0]    req_y;
  logic [NREQ*CD-1:0]   req_color;
  logic [NREQ-1:0]      gnt;
  logic                 clear_start;
  logic                 clear_busy, clear_done;
  logic [7:0]           vga_x;
  logic [6:0]           vga_y;
  logic [CD-1:0]        vga_color;
  logic                 vga_write;
  logic                 dbg_state;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_clear;
  int          m_pix;
  int          m_ptr;
  int          m_last_gi;
  logic [7:0]  rx [NREQ];
  logic [6:0]  ry [NREQ];
  logic [CD-1:0] rc [NREQ];
  logic [7:0]  e_x;
  logic [6:0]  e_y;
  logic [CD-1:0] e_c;
  logic        e_w, e_busy, e_done;
  int          clear_writes;

  vga_plot_arbiter #(.NREQ(NREQ), .X_MAX(XM), .Y_MAX(YM), .COLOR_DEPTH(CD), .BG_COLOR(BG)) dut (
    .CLOCK_50(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_color(req_color), .gnt(gnt), .clear_start(clear_start), .clear_busy(clear_busy),
    .clear_done(clear_done), .VGA_x(vga_x), .VGA_y(vga_y), .VGA_color(vga_color),
    .VGA_write(vga_write), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("write", 32'(vga_write), 32'(e_w));
    check("x", 32'(vga_x), 32'(e_x));
    check("y", 32'(vga_y), 32'(e_y));
    check("color", 32'(vga_color), 32'(e_c));
    check("busy", 32'(clear_busy), 32'(e_busy));
    check("done", 32'(clear_done), 32'(e_done));
    check("dbg", 32'(dbg_state), 32'(m_clear));
  endtask

  // One clock cycle: drive inputs, check grant, advance model, check registered outputs.
  task automatic step(input logic [NREQ-1:0] r, input logic cs);
    logic [NREQ-1:0] eg;
    int gi;
    req = r;
    clear_start = cs;
    for (int i = 0; i < NREQ; i++) begin
      req_x[8*i +: 8]      = rx[i];
      req_y[7*i +: 7]      = ry[i];
      req_color[CD*i +: CD] = rc[i];
    end
    #1;
    eg = '0;
    gi = -1;
    if (!m_clear && !cs)
      for (int k = 0; k < NREQ; k++)
        if (gi < 0 && r[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
    if (gi >= 0) eg[gi] = 1'b1;
    check("gnt", 32'(gnt), 32'(eg));
    m_last_gi = gi;
    if (m_clear) begin
      if (m_pix == NPIX - 1) begin
        m_clear = 0; e_w = 0; e_busy = 0; e_done = 0;
      end else begin
        m_pix++;
        e_x = 8'(m_pix % XM); e_y = 7'(m_pix / XM); e_c = BG;
        e_w = 1; e_done = (m_pix == NPIX - 1);
      end
    end else if (cs) begin
      m_clear = 1; m_pix = 0;
      e_x = 0; e_y = 0; e_c = BG; e_w = 1; e_busy = 1; e_done = 0;
    end else if (gi >= 0) begin
      e_x = rx[gi]; e_y = ry[gi]; e_c = rc[gi]; e_w = 1; e_done = 0;
      m_ptr = (gi + 1) % NREQ;
    end else begin
      e_w = 0; e_done = 0;
    end
    @(posedge clk);
    #1;
    if (vga_write && clear_busy) clear_writes++;
    check_outputs();
  endtask

  task automatic new_data(input int i);
    rx[i] = 8'($urandom_range(0, XM - 1));
    ry[i] = 7'($urandom_range(0, YM - 1));
    rc[i] = CD'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '1;
    clear_start = 1'b0;
    #1;
    m_clear = 0; m_pix = 0; m_ptr = 0;
    e_x = 0; e_y = 0; e_c = 0; e_w = 0; e_busy = 0; e_done = 0;
    check("rst_gnt", 32'(gnt), 32'd0);
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_gnt", 32'(gnt), 32'd0);
    reset = 1'b0;
  endtask

  // Runs the sweep to completion (or until a cycle budget expires).
  task automatic run_clear(input logic [NREQ-1:0] r, input int restart_at);
    int n = 0;
    while (m_clear && n < NPIX + 100) begin
      step(r, (m_pix == restart_at) ? 1'b1 : 1'b0);
      if (clear_done) begin
        check("done_x", 32'(vga_x), 32'(XM - 1));
        check("done_y", 32'(vga_y), 32'(YM - 1));
      end
      n++;
    end
    check("clear_timeout", 32'(m_clear), 32'd0);
  endtask

  initial begin
    logic [NREQ-1:0] pend;
    reset = 1'b1;
    req = '0;
    clear_start = 1'b0;
    req_x = '0; req_y = '0; req_color = '0;
    for (int i = 0; i < NREQ; i++) new_data(i);
    @(posedge clk);
    #1;
    do_reset();

    // single requester 1
    rx[1] = 8'd10; ry[1] = 7'd20; rc[1] = 9'h1C0;
    step(3'b010, 1'b0);
    check("t1_x", 32'(vga_x), 32'd10);
    check("t1_y", 32'(vga_y), 32'd20);
    check("t1_c", 32'(vga_color), 32'h1C0);
    check("t1_w", 32'(vga_write), 32'd1);
    step(3'b000, 1'b0);
    check("t1_idle", 32'(vga_write), 32'd0);

    // all three requesting from reset: rotation 0,1,2,0,1,2
    do_reset();
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) new_data(i);
      step(3'b111, 1'b0);
      check("t2_order", 32'(m_last_gi), 32'(c % NREQ));
    end

    // full clear with requester 0 waiting
    step(3'b000, 1'b0);
    clear_writes = 0;
    new_data(0);
    step(3'b001, 1'b1);
    run_clear(3'b001, -1);
    check("t3_count", 32'(clear_writes), 32'(NPIX));
    step(3'b001, 1'b0);
    check("t3_req0", 32'(m_last_gi), 32'd0);

    // clear re-pulsed at pixel 500 must not restart
    clear_writes = 0;
    step(3'b000, 1'b1);
    run_clear(3'b000, 500);
    check("t4_count", 32'(clear_writes), 32'(NPIX));

    // reset in the middle of a sweep
    step(3'b000, 1'b1);
    while (m_pix < 1000) step(3'b000, 1'b0);
    do_reset();
    check("t5_nodone", 32'(clear_done), 32'd0);
    new_data(0);
    step(3'b001, 1'b0);
    check("t5_lat", 32'(vga_write), 32'd1);

    // requester 2 alone, back to back
    for (int c = 0; c < 4; c++) begin
      new_data(2);
      step(3'b100, 1'b0);
      check("t6_gnt", 32'(m_last_gi), 32'd2);
    end

    // random traffic honoring hold-until-granted
    pend = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          new_data(i);
        end
      step(pend, 1'b0);
      if (m_last_gi >= 0) pend[m_last_gi] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
